add_sub_serial: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor that supersedes the fixed 4-bit ripple adder/subtractor. Operands of WIDTH bits are processed DIGIT bits per clock, LSB digit first, through a registered carry chain. Valid/ready handshakes sit on the operand input and the result output, and the block reports carry/borrow, signed overflow, zero and negative status. It sits between operand registers and the result/flag writeback path in the datapath.

---
 rtl/add_sub_serial.sv | 142 ++++++++++++++
 tb/tb_add_sub_serial.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor. DIGIT bits are summed per cycle,
// LSB digit first, through a registered carry. Valid/ready handshakes sit on both sides.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_sum_full;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_result_next;

  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_dig = r_a[i*DIGIT +: DIGIT];
        w_b_dig = r_b[i*DIGIT +: DIGIT];
      end
    end
  end

  assign w_sum_full = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  assign w_sum      = w_sum_full[DIGIT-1:0];
  assign w_cout     = w_sum_full[DIGIT];
  // Carry into the top bit of the digit recovered from its sum bit: s = a ^ b ^ cin.
  assign w_cmsb     = w_sum[DIGIT-1] ^ w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1];
  assign w_last     = (r_idx == IDXW'(NDIG - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign w_result_next[gi*DIGIT +: DIGIT] =
        (r_idx == IDXW'(gi)) ? w_sum : r_result[gi*DIGIT +: DIGIT];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_sub      <= sub;
            r_carry    <= carry_in ^ sub;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_result <= w_result_next;
          r_carry  <= w_cout;
          if (w_last) begin
            r_carry_out <= r_sub ? ~w_cout : w_cout;
            r_overflow  <= w_cmsb ^ w_cout;
            r_zero      <= (w_result_next == '0);
            r_negative  <= w_result_next[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign negative  = r_negative;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: three instances (DIGIT 16, 4, 1) at WIDTH 16, directed cases
// plus randomized operations checked against a plain-arithmetic reference.
module tb_add_sub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] a         [3];
  logic [15:0] b         [3];
  logic        sub       [3];
  logic        carry_in  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] result    [3];
  logic        carry_out [3];
  logic        overflow  [3];
  logic        zero      [3];
  logic        negative  [3];

  int n_pass   = 0;
  int n_checks = 0;
  int ndig_of [3] = '{1, 4, 16};

  always #5 clk = ~clk;

  add_sub_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .sub(sub[0]), .carry_in(carry_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
    .carry_out(carry_out[0]), .overflow(overflow[0]), .zero(zero[0]), .negative(negative[0]));

  add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .sub(sub[1]), .carry_in(carry_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
    .carry_out(carry_out[1]), .overflow(overflow[1]), .zero(zero[1]), .negative(negative[1]));

  add_sub_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .sub(sub[2]), .carry_in(carry_in[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(result[2]),
    .carry_out(carry_out[2]), .overflow(overflow[2]), .zero(zero[2]), .negative(negative[2]));

  // Reference: {result, carry/borrow, overflow, zero, negative} from integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic ms, input logic mc);
    int          ua, ub, u, sa, sb, t, ci;
    logic [15:0] r;
    logic        co, ov;
    ua = int'({16'h0, ma});
    ub = int'({16'h0, mb});
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ci = mc ? 1 : 0;
    if (ms) begin
      u  = ua - ub - ci;
      t  = sa - sb - ci;
      co = (u < 0);
    end else begin
      u  = ua + ub + ci;
      t  = sa + sb + ci;
      co = (u > 65535);
    end
    r  = u[15:0];
    ov = (t > 32767) || (t < -32768);
    return {r, co, ov, (r == 16'h0), r[15]};
  endfunction

  function automatic logic [19:0] observe(input int k);
    return {result[k], carry_out[k], overflow[k], zero[k], negative[k]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Offers one operand set, scrambles the inputs after acceptance, and counts edges to out_valid.
  task automatic issue(input int k, input logic [15:0] ta, input logic [15:0] tb2,
                       input logic ts, input logic tc, output int lat);
    @(negedge clk);
    a[k] = ta; b[k] = tb2; sub[k] = ts; carry_in[k] = tc; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a[k] = 16'($urandom); b[k] = 16'($urandom);
    sub[k] = 1'($urandom); carry_in[k] = 1'($urandom);
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op k=%0d a=%h b=%h sub=%0d cin=%0d -> res=%h c=%0d v=%0d z=%0d n=%0d lat=%0d",
             k, ta, tb2, ts, tc, result[k], carry_out[k], overflow[k], zero[k], negative[k], lat);
  endtask

  task automatic consume(input int k);
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({in_ready[k], out_valid[k], observe(k)} !== {1'b1, 1'b0, 20'h0}) begin
        $display("FAIL reset_state k=%0d got rdy=%0d vld=%0d out=%h want rdy=1 vld=0 out=00000",
                 k, in_ready[k], out_valid[k], observe(k));
      end else n_pass++;
    end
  endtask

  task automatic test_directed();
    logic [15:0] da [5];
    logic [15:0] db [5];
    logic        ds [5];
    logic [19:0] dexp [5];
    int          lat;
    da   = '{16'h1234, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF};
    db   = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h0001};
    ds   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    dexp = '{{16'h2233, 4'b0000}, {16'hFFFE, 4'b1001}, {16'h7FFF, 4'b0100},
             {16'h8000, 4'b0101}, {16'h0000, 4'b1010}};
    for (int i = 0; i < 5; i++) begin
      issue(1, da[i], db[i], ds[i], 1'b0, lat);
      n_checks++;
      if (observe(1) !== dexp[i]) begin
        $display("FAIL directed_%0d got %h want %h", i, observe(1), dexp[i]);
      end else n_pass++;
      n_checks++;
      if (lat != 4) begin
        $display("FAIL directed_latency_%0d got %0d want 4", i, lat);
      end else n_pass++;
      consume(1);
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [19:0] snap;
    logic [19:0] exp_v;
    issue(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    snap = observe(1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a[1] = 16'hAAAA; b[1] = 16'h5555; sub[1] = 1'b0; carry_in[1] = 1'b1;
      in_valid[1] = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid[1], in_ready[1], observe(1)} !== {1'b1, 1'b0, snap}) begin
        $display("FAIL backpressure_hold_%0d got vld=%0d rdy=%0d out=%h want vld=1 rdy=0 out=%h",
                 c, out_valid[1], in_ready[1], observe(1), snap);
      end else n_pass++;
    end
    in_valid[1] = 1'b0;
    consume(1);
    n_checks++;
    if ({in_ready[1], out_valid[1]} !== 2'b10) begin
      $display("FAIL backpressure_release got rdy=%0d vld=%0d want rdy=1 vld=0",
               in_ready[1], out_valid[1]);
    end else n_pass++;
    issue(1, 16'h0101, 16'h0202, 1'b0, 1'b0, lat);
    exp_v = model(16'h0101, 16'h0202, 1'b0, 1'b0);
    n_checks++;
    if (observe(1) !== exp_v) begin
      $display("FAIL backpressure_next_op got %h want %h", observe(1), exp_v);
    end else n_pass++;
    consume(1);
  endtask

  task automatic test_reset_busy();
    logic seen_valid;
    @(negedge clk);
    a[1] = 16'h1111; b[1] = 16'h2222; sub[1] = 1'b0; carry_in[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready[1], out_valid[1], observe(1)} !== {1'b1, 1'b0, 20'h0}) begin
      $display("FAIL reset_busy_state got rdy=%0d vld=%0d out=%h want rdy=1 vld=0 out=00000",
               in_ready[1], out_valid[1], observe(1));
    end else n_pass++;
    seen_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid[1] !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      $display("FAIL reset_busy_no_valid got out_valid seen=%0d want 0", seen_valid);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int          cyc;
    int          hs_cyc [3];
    int          nhs;
    logic [19:0] exp_v;
    exp_v = model(16'h4321, 16'h1111, 1'b1, 1'b1);
    @(negedge clk);
    a[1] = 16'h4321; b[1] = 16'h1111; sub[1] = 1'b1; carry_in[1] = 1'b1;
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    cyc = 0; nhs = 0;
    while (nhs < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid[1] === 1'b1) begin
        hs_cyc[nhs] = cyc;
        nhs++;
        n_checks++;
        if (observe(1) !== exp_v) begin
          $display("FAIL back_to_back_result_%0d got %h want %h", nhs, observe(1), exp_v);
        end else n_pass++;
        $display("op k=1 back_to_back handshake %0d at cycle %0d res=%h", nhs, cyc, result[1]);
      end
    end
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    n_checks++;
    if (nhs != 3) begin
      $display("FAIL back_to_back_count got %0d handshakes want 3", nhs);
    end else begin
      n_pass++;
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (hs_cyc[i] - hs_cyc[i-1] != 6) begin
          $display("FAIL back_to_back_spacing_%0d got %0d want 6", i, hs_cyc[i] - hs_cyc[i-1]);
        end else n_pass++;
      end
    end
    n_checks++;
    if (in_ready[1] !== 1'b1) begin
      $display("FAIL back_to_back_idle got rdy=%0d want 1", in_ready[1]);
    end else n_pass++;
  endtask

  task automatic test_sweep();
    int          lat;
    logic [15:0] ta, tb2;
    logic        ts, tc;
    logic [19:0] exp_v;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ta = pick(); tb2 = pick(); ts = 1'($urandom); tc = 1'($urandom);
        exp_v = model(ta, tb2, ts, tc);
        issue(k, ta, tb2, ts, tc, lat);
        n_checks++;
        if (observe(k) !== exp_v) begin
          $display("FAIL sweep_result k=%0d n=%0d got %h want %h", k, n, observe(k), exp_v);
        end else n_pass++;
        n_checks++;
        if (lat != ndig_of[k]) begin
          $display("FAIL sweep_latency k=%0d n=%0d got %0d want %0d", k, n, lat, ndig_of[k]);
        end else n_pass++;
        consume(k);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; a[k] = '0; b[k] = '0; sub[k] = 1'b0;
      carry_in[k] = 1'b0; out_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
